pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter: TIMEOUT, default 63, max MEM_WAIT cycles before error, range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low; sampled on rising clk edge.
REQ-004 hazard_Detected  in  1  ID-stage RAW hazard flag from hazard detection.
REQ-005 branch_taken  in  1  EXE-stage branch resolved taken.
REQ-006 mem_r_en  in  1  MEM-stage instruction reads memory.
REQ-007 mem_w_en  in  1  MEM-stage instruction writes memory.
REQ-008 sram_ready  in  1  SRAM access complete this cycle.
REQ-009 sram_start  out  1  one-cycle pulse, launches SRAM access.
REQ-010 freeze_front  out  1  hold PC and IF/ID register.
REQ-011 freeze_back  out  1  hold ID/EXE, EXE/MEM, MEM/WB registers.
REQ-012 flush_if_id  out  1  load NOP into IF/ID.
REQ-013 flush_id_exe  out  1  load bubble into ID/EXE.
REQ-014 mem_timeout  out  1  sticky SRAM timeout flag.
REQ-015 stall_cycles  out  16  stall-cycle statistic (see Configuration).

Function
REQ-016 FSM states SHALL be RUN, MEM_WAIT, ERROR; 8-bit wait counter wcnt.
REQ-017 mem_req SHALL be defined as mem_r_en OR mem_w_en.
REQ-018 RUN and mem_req: sram_start=1, freeze_back=1, freeze_front=1, no flushes; next state MEM_WAIT, wcnt<=0.
REQ-019 MEM_WAIT and sram_ready=0: freeze_back=1, freeze_front=1, no flushes, wcnt<=wcnt+1.
REQ-020 MEM_WAIT and sram_ready=1: all freezes 0 (pipeline advances this cycle); next state RUN.
REQ-021 Minimum memory access SHALL be 2 cycles (request cycle plus ready cycle); sram_ready in RUN SHALL be ignored.
REQ-022 MEM_WAIT, sram_ready=0 and wcnt==TIMEOUT-1: next state ERROR; sram_ready=1 in that cycle SHALL complete normally.
REQ-023 ERROR: freeze_front=1, freeze_back=1, no flushes, no sram_start, mem_timeout=1; exit only by reset.
REQ-024 RUN, no mem_req, branch_taken=1: flush_if_id=1, flush_id_exe=1, freeze_front=0; hazard_Detected ignored.
REQ-025 RUN, no mem_req, no branch, hazard_Detected=1: freeze_front=1, flush_id_exe=1, freeze_back=0.
REQ-026 RUN, no request/branch/hazard: all control outputs 0.
REQ-027 Priority SHALL be: ERROR > memory stall > branch flush > hazard stall.
REQ-028 Branch or hazard during a memory stall SHALL not flush; condition is re-evaluated once the pipeline advances.
REQ-029 Control outputs SHALL be combinational from current state and inputs; only state, wcnt, mem_timeout, stall_cycles are registered.
REQ-030 Back-to-back memory instructions: RUN with mem_req in the cycle after completion SHALL start a new access.

Reset
REQ-031 rst=0 at a clock edge: state<=RUN, wcnt<=0, mem_timeout<=0, stall_cycles<=0.
REQ-032 Reset mid-access or in ERROR SHALL abandon the access; no sram_start while rst=0; outputs follow RUN rules with registered state at reset values.

Configuration
REQ-033 Macro PIPELINE_CONTROLLER_STATS_EN: when defined, stall_cycles increments each cycle freeze_front=1 and rst=1, saturating at 16'hFFFF.
REQ-034 Without PIPELINE_CONTROLLER_STATS_EN, stall_cycles SHALL be constant 0 and the counter SHALL not be synthesized; all other behaviour identical.

Verification
REQ-035 Load in MEM, sram_ready high 3 cycles after sram_start -> sram_start one pulse, freeze_back=1 for 3 cycles, 0 on 4th, state RUN.
REQ-036 hazard_Detected=1 with branch_taken=1, no mem_req -> flush_if_id=1, flush_id_exe=1, freeze_front=0.
REQ-037 mem_w_en=1 with hazard_Detected=1 -> freeze_front=1, freeze_back=1, flush_id_exe=0 until sram_ready.
REQ-038 TIMEOUT=4, sram_ready never -> ERROR after 4 MEM_WAIT cycles, mem_timeout=1 and all frozen until rst=0; ready on 4th cycle -> RUN, mem_timeout=0.
REQ-039 Reset asserted in MEM_WAIT -> next cycle state RUN, mem_timeout=0, no sram_start during reset.
REQ-040 With STATS_EN, 3 hazard cycles plus one 2-cycle load -> stall_cycles=4; preset near 16'hFFFF -> saturates; without macro -> reads 0.

Source files
------------

// File: rtl/pipeline_controller_if.sv
// Pipeline-control bundle between the datapath/hazard unit and the pipeline controller.
// Latency: none, plain wires.
// Backpressure: freeze_* and sram_ready carry stall/completion; no valid/ready pairs inside.
// Ports (signals):
//   hazard_Detected, branch_taken, mem_r_en, mem_w_en, sram_ready : datapath -> controller
//   sram_start, freeze_front, freeze_back, flush_if_id, flush_id_exe,
//   mem_timeout, stall_cycles[15:0]                                 : controller -> datapath
// Modports: master = datapath side, slave = controller side.
interface pipeline_controller_if;
    logic        hazard_Detected;
    logic        branch_taken;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        sram_ready;
    logic        sram_start;
    logic        freeze_front;
    logic        freeze_back;
    logic        flush_if_id;
    logic        flush_id_exe;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    modport master (
        output hazard_Detected, branch_taken, mem_r_en, mem_w_en, sram_ready,
        input  sram_start, freeze_front, freeze_back, flush_if_id, flush_id_exe,
        input  mem_timeout, stall_cycles
    );

    modport slave (
        input  hazard_Detected, branch_taken, mem_r_en, mem_w_en, sram_ready,
        output sram_start, freeze_front, freeze_back, flush_if_id, flush_id_exe,
        output mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller: memory stalls, branch flushes, hazard bubbles, SRAM timeout.
// Latency: control outputs combinational from state+inputs; state/wcnt/mem_timeout/stats registered.
// Backpressure: holds the whole pipeline while an SRAM access is outstanding or after a timeout.
// Ports: clk (rising edge), rst (synchronous, active-low), bus (pipeline_controller_if.slave).
// Parameter TIMEOUT (1..255): MEM_WAIT cycles without sram_ready before entering ERROR.
// Optional feature macro PIPELINE_CONTROLLER_STATS_EN: enables the stall_cycles counter.
module pipeline_controller #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt, state_eff;
    logic [7:0] wcnt, wcnt_nxt;
    logic       mem_timeout_q;
    logic       mem_req;
    logic       sram_start, freeze_front, freeze_back, flush_if_id, flush_id_exe;

    assign mem_req = bus.mem_r_en | bus.mem_w_en;

    // While reset is held the outputs behave as if already in RUN, so a
    // pending access is abandoned immediately rather than one cycle later.
    assign state_eff = rst ? state : RUN;

    always_comb begin
        sram_start   = 1'b0;
        freeze_front = 1'b0;
        freeze_back  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        state_nxt    = state;
        wcnt_nxt     = wcnt;
        case (state_eff)
            RUN: begin
                // sram_ready is ignored here: every access waits at least one MEM_WAIT cycle.
                if (mem_req) begin
                    sram_start   = rst;
                    freeze_front = 1'b1;
                    freeze_back  = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wcnt_nxt     = 8'd0;
                end else if (bus.branch_taken) begin
                    flush_if_id  = 1'b1;
                    flush_id_exe = 1'b1;
                end else if (bus.hazard_Detected) begin
                    freeze_front = 1'b1;
                    flush_id_exe = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Branch/hazard are not acted on here; they are seen again once
                // the pipeline advances back in RUN.
                if (bus.sram_ready) begin
                    state_nxt = RUN;
                end else begin
                    freeze_front = 1'b1;
                    freeze_back  = 1'b1;
                    wcnt_nxt     = wcnt + 8'd1;
                    if (wcnt == WCNT_LAST) begin
                        state_nxt = ERROR;
                    end
                end
            end
            ERROR: begin
                freeze_front = 1'b1;
                freeze_back  = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= RUN;
            wcnt          <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (state_nxt == ERROR) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.sram_start   = sram_start;
    assign bus.freeze_front = freeze_front;
    assign bus.freeze_back  = freeze_back;
    assign bus.flush_if_id  = flush_if_id;
    assign bus.flush_id_exe = flush_id_exe;
    assign bus.mem_timeout  = mem_timeout_q;

`ifdef PIPELINE_CONTROLLER_STATS_EN
    logic [15:0] stall_q;

    // Counts cycles the front end is held, saturating rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= 16'd0;
        end else if (freeze_front && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed literal cases plus randomized traffic
// against a behavioural model (access age / dead flag / stall count).
// Runs with TIMEOUT=4; honours PIPELINE_CONTROLLER_STATS_EN for stall_cycles expectations.
module tb_pipeline_controller;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    pipeline_controller_if bus ();

    pipeline_controller #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

`ifdef PIPELINE_CONTROLLER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: age = cycles spent waiting on the current access (0 = none),
    // dead = timed out, stall = saturating count of frozen-front cycles.
    int       m_age   = 0;
    bit       m_dead  = 1'b0;
    int       m_stall = 0;

    always @(negedge clk) begin
        bit req, e_start, e_ff, e_fb, e_fi, e_fe;
        req     = bus.mem_r_en | bus.mem_w_en;
        e_start = 1'b0; e_ff = 1'b0; e_fb = 1'b0; e_fi = 1'b0; e_fe = 1'b0;
        if (rst && m_dead) begin
            e_ff = 1'b1; e_fb = 1'b1;
        end else if (rst && m_age > 0) begin
            if (!bus.sram_ready) begin e_ff = 1'b1; e_fb = 1'b1; end
        end else if (req) begin
            e_start = rst; e_ff = 1'b1; e_fb = 1'b1;
        end else if (bus.branch_taken) begin
            e_fi = 1'b1; e_fe = 1'b1;
        end else if (bus.hazard_Detected) begin
            e_ff = 1'b1; e_fe = 1'b1;
        end
        if (chk_en) begin
            chk("m_sram_start",   {15'd0, bus.sram_start},   {15'd0, e_start});
            chk("m_freeze_front", {15'd0, bus.freeze_front}, {15'd0, e_ff});
            chk("m_freeze_back",  {15'd0, bus.freeze_back},  {15'd0, e_fb});
            chk("m_flush_if_id",  {15'd0, bus.flush_if_id},  {15'd0, e_fi});
            chk("m_flush_id_exe", {15'd0, bus.flush_id_exe}, {15'd0, e_fe});
            chk("m_mem_timeout",  {15'd0, bus.mem_timeout},  {15'd0, m_dead});
            chk("m_stall_cycles", bus.stall_cycles,          16'(m_stall));
        end
        // state that will be in effect after the next rising edge
        if (!rst) begin
            m_age = 0; m_dead = 1'b0; m_stall = 0;
        end else begin
            if (STATS && e_ff && m_stall < 65535) m_stall++;
            if (m_dead) begin
                // sticky until reset
            end else if (m_age > 0) begin
                if (bus.sram_ready) m_age = 0;
                else if (m_age == TO) begin m_dead = 1'b1; m_age = 0; end
                else m_age++;
            end else if (req) begin
                m_age = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit hz, input bit br, input bit rd, input bit wr, input bit rdy);
        bus.hazard_Detected = hz;
        bus.branch_taken    = br;
        bus.mem_r_en        = rd;
        bus.mem_w_en        = wr;
        bus.sram_ready      = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
    endtask

    // Literal check of the five control outputs in the current cycle.
    task automatic chk_ctl(input string name, input bit st, input bit ff, input bit fb,
                           input bit fi, input bit fe);
        @(negedge clk);
        chk(name, {11'd0, bus.sram_start, bus.freeze_front, bus.freeze_back,
                   bus.flush_if_id, bus.flush_id_exe}, {11'd0, st, ff, fb, fi, fe});
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(0, 0, 0, 0, 0);
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        chk_en = 1'b1;

        // after reset: idle RUN
        chk_ctl("reset_idle", 0, 0, 0, 0, 0);
        chk("reset_timeout", {15'd0, bus.mem_timeout}, 16'd0);
        chk("reset_stats", bus.stall_cycles, 16'd0);

        // load, ready three cycles after the start pulse
        tick(); set_in(0, 0, 1, 0, 0);
        chk_ctl("ld_start", 1, 1, 1, 0, 0);
        tick(); chk_ctl("ld_wait1", 0, 1, 1, 0, 0);
        tick(); chk_ctl("ld_wait2", 0, 1, 1, 0, 0);
        tick(); bus.sram_ready = 1'b1;
        chk_ctl("ld_ready", 0, 0, 0, 0, 0);
        tick(); set_in(0, 0, 0, 0, 0);
        chk_ctl("ld_back_run", 0, 0, 0, 0, 0);

        // branch beats hazard
        tick(); set_in(1, 1, 0, 0, 0);
        chk_ctl("br_over_hz", 0, 0, 0, 1, 1);

        // hazard alone
        tick(); set_in(1, 0, 0, 0, 0);
        chk_ctl("hz_only", 0, 1, 0, 0, 1);

        // store with hazard: memory stall wins, hazard resurfaces after
        tick(); set_in(1, 0, 0, 1, 0);
        chk_ctl("st_hz_start", 1, 1, 1, 0, 0);
        tick(); chk_ctl("st_hz_wait", 0, 1, 1, 0, 0);
        tick(); bus.sram_ready = 1'b1;
        chk_ctl("st_hz_ready", 0, 0, 0, 0, 0);
        tick(); set_in(1, 0, 0, 0, 0);
        chk_ctl("st_hz_after", 0, 1, 0, 0, 1);

        // back-to-back loads
        tick(); set_in(0, 0, 1, 0, 0);
        tick(); bus.sram_ready = 1'b1;
        tick(); bus.sram_ready = 1'b0;
        chk_ctl("b2b_second_start", 1, 1, 1, 0, 0);
        tick(); bus.sram_ready = 1'b1;
        tick(); set_in(0, 0, 0, 0, 0);

        // timeout: four wait cycles without ready
        tick(); set_in(0, 0, 1, 0, 0);
        for (int i = 0; i < TO; i++) begin
            tick();
            @(negedge clk);
            chk("to_wait_flag", {15'd0, bus.mem_timeout}, 16'd0);
        end
        tick(); set_in(1, 1, 0, 0, 1);
        chk_ctl("to_error_frozen", 0, 1, 1, 0, 0);
        chk("to_error_flag", {15'd0, bus.mem_timeout}, 16'd1);
        tick(); set_in(0, 0, 1, 0, 0);
        chk_ctl("to_error_no_start", 0, 1, 1, 0, 0);
        do_reset();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("to_cleared", {15'd0, bus.mem_timeout}, 16'd0);

        // ready on the last allowed wait cycle completes normally
        tick(); set_in(0, 0, 1, 0, 0);
        tick(); tick(); tick();
        tick(); bus.sram_ready = 1'b1;
        chk_ctl("to_edge_ready", 0, 0, 0, 0, 0);
        tick(); set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("to_edge_flag", {15'd0, bus.mem_timeout}, 16'd0);

        // reset during MEM_WAIT abandons the access
        tick(); set_in(0, 0, 1, 0, 0);
        tick();
        tick(); rst = 1'b0;
        chk_ctl("rst_mid_no_start", 0, 1, 1, 0, 0);
        tick(); rst = 1'b1;
        chk_ctl("rst_mid_restart", 1, 1, 1, 0, 0);
        tick(); bus.sram_ready = 1'b1;
        tick(); set_in(0, 0, 0, 0, 0);

        // stall statistic: 3 hazard cycles + one 2-cycle load
        do_reset();
        set_in(1, 0, 0, 0, 0);
        tick(); tick(); tick();
        set_in(0, 0, 1, 0, 0);
        tick(); bus.sram_ready = 1'b1;
        tick(); set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stats_four", bus.stall_cycles, STATS ? 16'd4 : 16'd0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst = ($urandom_range(0, 99) >= 2);
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                   $urandom_range(0, 9) < 4);
        end

`ifdef PIPELINE_CONTROLLER_STATS_EN
        // saturation: sit in ERROR long enough to overflow 16 bits
        tick(); do_reset();
        set_in(0, 0, 1, 0, 0);
        repeat (TO + 2) tick();
        set_in(0, 0, 0, 0, 0);
        repeat (65540) tick();
        @(negedge clk);
        chk("stats_saturate", bus.stall_cycles, 16'hFFFF);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
